// File: rtl/lfsr_pkg.sv
// Shared types and the single-step LFSR function used by every channel.
package lfsr_pkg;

    localparam int unsigned MAX_W = 32;

    typedef enum logic {
        RUN  = 1'b0,
        LOAD = 1'b1
    } fsm_t;

    // Next Fibonacci state; an all-zero state is reseeded (seed, or 1 if seed is zero).
    function automatic logic [MAX_W-1:0] lfsr_step(
        input logic [MAX_W-1:0] state,
        input logic [MAX_W-1:0] taps,
        input logic [MAX_W-1:0] seed,
        input int unsigned      width
    );
        logic             fb;
        logic [MAX_W-1:0] nxt;
        fb  = 1'b0;
        nxt = '0;
        if (state == '0) begin
            nxt = (seed == '0) ? MAX_W'(1) : seed;
        end else begin
            fb  = ^(state & taps);
            nxt = (state >> 1) | (MAX_W'(fb) << (width - 1));
        end
        return nxt;
    endfunction

endpackage

// File: rtl/lfsr_channel.sv
// One LFSR channel: state, taps and seed window plus sticky lockup/wrap flags.
module lfsr_channel
    import lfsr_pkg::*;
#(
    parameter int unsigned      WIDTH    = 5,
    parameter logic [WIDTH-1:0] RST_SEED = '0,
    parameter logic [WIDTH-1:0] RST_TAPS = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             step,
    input  logic             load,
    input  logic [WIDTH-1:0] seed_win,
    input  logic [WIDTH-1:0] taps_win,
    output logic             bit_out,
    output logic             lockup,
    output logic             wrapped
);

    logic [WIDTH-1:0] state;
    logic [WIDTH-1:0] taps;
    logic [WIDTH-1:0] seed;
    logic [WIDTH-1:0] nxt;
    logic             zero;

    // Candidate next state for this channel.
    always_comb begin
        zero = (state == '0);
        nxt  = WIDTH'(lfsr_step(MAX_W'(state), MAX_W'(taps), MAX_W'(seed), WIDTH));
    end

    // Load takes priority over stepping; a reseed never counts as a wrap.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= RST_SEED;
            taps    <= RST_TAPS;
            seed    <= RST_SEED;
            lockup  <= 1'b0;
            wrapped <= 1'b0;
        end else if (load) begin
            state   <= seed_win;
            taps    <= taps_win;
            seed    <= seed_win;
            lockup  <= 1'b0;
            wrapped <= 1'b0;
        end else if (step) begin
            state <= nxt;
            if (zero) begin
                lockup <= 1'b1;
            end else if (nxt == seed) begin
                wrapped <= 1'b1;
            end
        end
    end

    assign bit_out = state[0];

endmodule

// File: rtl/lfsr_bank.sv
// Bank of Fibonacci LFSR channels with internal step divider and config handshake.
module lfsr_bank
    import lfsr_pkg::*;
#(
    parameter int unsigned                WIDTH    = 5,
    parameter int unsigned                CHANNELS = 7,
    parameter int unsigned                TICK_DIV = 50_000_000,
    parameter logic [WIDTH+CHANNELS-2:0]  SEED     = 11'b10101010101,
    parameter logic [WIDTH+CHANNELS-2:0]  TAPS     = 11'b11001100110
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         en,
    input  logic                         step_now,
    input  logic                         cfg_valid,
    output logic                         cfg_ready,
    input  logic [WIDTH+CHANNELS-2:0]    cfg_seed,
    input  logic [WIDTH+CHANNELS-2:0]    cfg_taps,
    output logic [CHANNELS-1:0]          out,
    output logic                         tick,
    output logic [CHANNELS-1:0]          lockup,
    output logic [CHANNELS-1:0]          wrapped
);

    localparam int unsigned    VW      = WIDTH + CHANNELS - 1;
    localparam int unsigned    CNT_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

    fsm_t             fsm;
    fsm_t             fsm_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [VW-1:0]    seed_q;
    logic [VW-1:0]    taps_q;
    logic             fire;
    logic             hs;
    logic             load;
    logic             step;

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fsm <= RUN;
        end else begin
            fsm <= fsm_nxt;
        end
    end

    // Next state, handshake and step decode; a handshake swallows any pending step.
    always_comb begin
        fsm_nxt   = fsm;
        cfg_ready = 1'b0;
        hs        = 1'b0;
        load      = 1'b0;
        step      = 1'b0;
        fire      = en ? (cnt == CNT_MAX) : step_now;
        case (fsm)
            RUN: begin
                cfg_ready = 1'b1;
                if (cfg_valid) begin
                    hs      = 1'b1;
                    fsm_nxt = LOAD;
                end else begin
                    step = fire;
                end
            end
            LOAD: begin
                load    = 1'b1;
                fsm_nxt = RUN;
            end
            default: fsm_nxt = RUN;
        endcase
        tick = step;
    end

    // Divider: counts while enabled, wraps on the terminal count, cleared by LOAD or en=0.
    always_comb begin
        cnt_nxt = '0;
        if (!load && en && (cnt != CNT_MAX)) begin
            cnt_nxt = cnt + CNT_W'(1);
        end
    end

    // Divider register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_nxt;
        end
    end

    // Config capture on the handshake cycle only.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            seed_q <= SEED;
            taps_q <= TAPS;
        end else if (hs) begin
            seed_q <= cfg_seed;
            taps_q <= cfg_taps;
        end
    end

    // Channel i sees the sliding window [i+WIDTH-1:i] of the shared vectors.
    for (genvar g = 0; g < int'(CHANNELS); g++) begin : g_ch
        lfsr_channel #(
            .WIDTH    (WIDTH),
            .RST_SEED (SEED[g +: WIDTH]),
            .RST_TAPS (TAPS[g +: WIDTH])
        ) u_ch (
            .clk      (clk),
            .reset    (reset),
            .step     (step),
            .load     (load),
            .seed_win (seed_q[g +: WIDTH]),
            .taps_win (taps_q[g +: WIDTH]),
            .bit_out  (out[g]),
            .lockup   (lockup[g]),
            .wrapped  (wrapped[g])
        );
    end

endmodule

// File: tb/tb_lfsr_bank.sv
// Self-checking bench for lfsr_bank: vector table, directed corners, randomized model compare.
module tb_lfsr_bank;

    localparam int unsigned W    = 5;
    localparam int unsigned C    = 7;
    localparam int unsigned VW   = W + C - 1;
    localparam int unsigned TD   = 4;
    localparam int unsigned MASK = (1 << W) - 1;
    localparam logic [VW-1:0] SEED_V = 11'b10101010101;
    localparam logic [VW-1:0] TAPS_V = 11'b11001100110;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          en = 1'b0;
    logic          step_now = 1'b0;
    logic          cfg_valid = 1'b0;
    logic          cfg_ready;
    logic [VW-1:0] cfg_seed = '0;
    logic [VW-1:0] cfg_taps = '0;
    logic [C-1:0]  out;
    logic          tick;
    logic [C-1:0]  lockup;
    logic [C-1:0]  wrapped;

    logic       reset4 = 1'b0;
    logic       en4 = 1'b0;
    logic       cfg_ready4;
    logic [0:0] out4;
    logic       tick4;
    logic [0:0] lockup4;
    logic [0:0] wrapped4;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    lfsr_bank #(
        .WIDTH(W), .CHANNELS(C), .TICK_DIV(TD), .SEED(SEED_V), .TAPS(TAPS_V)
    ) dut (
        .clk(clk), .reset(reset), .en(en), .step_now(step_now),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_seed(cfg_seed), .cfg_taps(cfg_taps),
        .out(out), .tick(tick), .lockup(lockup), .wrapped(wrapped)
    );

    lfsr_bank #(
        .WIDTH(4), .CHANNELS(1), .TICK_DIV(1), .SEED(4'b0001), .TAPS(4'b0011)
    ) dut4 (
        .clk(clk), .reset(reset4), .en(en4), .step_now(1'b0),
        .cfg_valid(1'b0), .cfg_ready(cfg_ready4),
        .cfg_seed(4'b0000), .cfg_taps(4'b0000),
        .out(out4), .tick(tick4), .lockup(lockup4), .wrapped(wrapped4)
    );

    // Reference model: per-channel integers stepped by the textual rules.
    int unsigned   m_st[C];
    int unsigned   m_tp[C];
    int unsigned   m_sd[C];
    bit [C-1:0]    m_lk;
    bit [C-1:0]    m_wr;
    int unsigned   m_phase;
    bit            m_loading;
    logic [VW-1:0] m_pseed;
    logic [VW-1:0] m_ptaps;

    logic          s_tick;
    logic          s_ready;
    logic [C-1:0]  s_out;
    logic [C-1:0]  s_lock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int unsigned mstep(input int unsigned s, input int unsigned t,
                                          input int unsigned sd, input int unsigned w,
                                          output bit lk, output bit wr);
        int unsigned n;
        lk = 1'b0;
        wr = 1'b0;
        if (s == 0) begin
            lk = 1'b1;
            return (sd == 0) ? 1 : sd;
        end
        n  = (s >> 1) + (($countones(s & t) % 2) << (w - 1));
        wr = (n == sd);
        return n;
    endfunction

    function automatic logic [C-1:0] m_out();
        logic [C-1:0] r;
        for (int i = 0; i < int'(C); i++) r[i] = m_st[i][0];
        return r;
    endfunction

    task automatic model_load(input logic [VW-1:0] sv, input logic [VW-1:0] tv);
        for (int i = 0; i < int'(C); i++) begin
            m_st[i] = (32'(sv) >> i) & MASK;
            m_tp[i] = (32'(tv) >> i) & MASK;
            m_sd[i] = m_st[i];
        end
        m_lk = '0;
        m_wr = '0;
    endtask

    task automatic model_reset();
        model_load(SEED_V, TAPS_V);
        m_phase   = 0;
        m_loading = 1'b0;
    endtask

    // One clock: compare against the model just before the edge, then advance the model.
    task automatic cycle();
        bit hs, fire, et, lk, wr;
        #1;
        hs   = !m_loading && cfg_valid;
        fire = en ? (m_phase == TD - 1) : step_now;
        et   = !m_loading && !hs && fire;
        s_tick = tick; s_ready = cfg_ready; s_out = out; s_lock = lockup;
        chk("tick", 32'(tick), 32'(et));
        chk("cfg_ready", 32'(cfg_ready), 32'(!m_loading));
        chk("out", 32'(out), 32'(m_out()));
        chk("lockup", 32'(lockup), 32'(m_lk));
        chk("wrapped", 32'(wrapped), 32'(m_wr));
        @(posedge clk);
        if (m_loading) begin
            model_load(m_pseed, m_ptaps);
            m_phase   = 0;
            m_loading = 1'b0;
        end else begin
            if (hs) begin
                m_pseed   = cfg_seed;
                m_ptaps   = cfg_taps;
                m_loading = 1'b1;
            end else if (et) begin
                for (int i = 0; i < int'(C); i++) begin
                    m_st[i] = mstep(m_st[i], m_tp[i], m_sd[i], W, lk, wr);
                    m_lk[i] = m_lk[i] | lk;
                    m_wr[i] = m_wr[i] | wr;
                end
            end
            m_phase = (en && m_phase != TD - 1) ? m_phase + 1 : 0;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b0; en = 1'b0; step_now = 1'b0; cfg_valid = 1'b0;
        #2;
        chk("rst_out", 32'(out), 32'(SEED_V[C-1:0]));
        chk("rst_ready", 32'(cfg_ready), 32'd1);
        chk("rst_tick", 32'(tick), 32'd0);
        chk("rst_flags", 32'({lockup, wrapped}), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        model_reset();
    endtask

    typedef struct {
        bit rst;
        bit en;
        bit step_now;
        bit exp_tick;
        bit exp_out0;
    } vec_t;

    vec_t vecs[15];

    initial begin
        logic [VW-1:0] sv;
        int gap;
        int first;
        int unsigned ms;
        bit mw, ml, lk, wr;

        // Auto stepping at TICK_DIV=4, then three single steps with en=0.
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[9]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[13] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

        @(negedge clk);
        for (int r = 0; r < 15; r++) begin
            if (vecs[r].rst) do_reset();
            en = vecs[r].en;
            step_now = vecs[r].step_now;
            cycle();
            chk("vec_tick", 32'(s_tick), 32'(vecs[r].exp_tick));
            chk("vec_out0", 32'(s_out[0]), 32'(vecs[r].exp_out0));
        end
        step_now = 1'b0;

        // en dropped on the would-be wrap cycle: no step.
        do_reset();
        en = 1'b1;
        repeat (3) cycle();
        en = 1'b0;
        cycle();
        chk("en_drop_tick", 32'(s_tick), 32'd0);

        // Handshake on the divider terminal cycle.
        do_reset();
        en = 1'b1;
        repeat (3) cycle();
        sv = VW'($urandom);
        cfg_valid = 1'b1; cfg_seed = sv; cfg_taps = VW'($urandom);
        cycle();
        chk("hs_tick", 32'(s_tick), 32'd0);
        cfg_valid = 1'b0; cfg_seed = '0; cfg_taps = '0;
        cycle();
        chk("load_ready", 32'(s_ready), 32'd0);
        cycle();
        chk("new_seed_out", 32'(s_out), 32'(sv[C-1:0]));
        gap = -1;
        for (int k = 1; k <= 10 && gap < 0; k++) begin
            cycle();
            if (s_tick) gap = k;
        end
        chk("restart_gap", 32'(gap), 32'd3);

        // Zero seed: lockup reseed to 1, then normal step to 10000.
        do_reset();
        cfg_valid = 1'b1; cfg_seed = '0; cfg_taps = '1;
        cycle();
        cfg_valid = 1'b0;
        cycle();
        step_now = 1'b1;
        cycle();
        chk("zero_out", 32'(s_out), 32'd0);
        step_now = 1'b0;
        cycle();
        chk("lock_flags", 32'(s_lock), 32'h7f);
        chk("lock_out", 32'(s_out), 32'h7f);
        step_now = 1'b1;
        cycle();
        step_now = 1'b0;
        cycle();
        chk("post_lock_out", 32'(s_out), 32'd0);

        // Randomized traffic against the model.
        do_reset();
        for (int k = 0; k < 600; k++) begin
            en        = ($urandom % 3) != 0;
            step_now  = $urandom % 2;
            cfg_valid = ($urandom % 20) == 0;
            cfg_seed  = VW'($urandom);
            cfg_taps  = VW'($urandom);
            cycle();
        end

        // Asynchronous reset while in LOAD discards the pending config.
        en = 1'b0; step_now = 1'b0;
        cfg_valid = 1'b1; cfg_seed = ~SEED_V; cfg_taps = '1;
        cycle();
        cfg_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("async_out", 32'(out), 32'(SEED_V[C-1:0]));
        chk("async_ready", 32'(cfg_ready), 32'd1);
        chk("async_flags", 32'({lockup, wrapped}), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        repeat (4) cycle();

        // WIDTH=4 maximal-length channel: first wrap after 15 steps.
        reset4 = 1'b1; en4 = 1'b1;
        ms = 1; mw = 1'b0; ml = 1'b0; first = -1;
        for (int k = 0; k < 20; k++) begin
            #1;
            chk("w4_wrapped", 32'(wrapped4), 32'(mw));
            chk("w4_lockup", 32'(lockup4), 32'(ml));
            chk("w4_out", 32'(out4), ms & 1);
            if (wrapped4[0] && first < 0) first = k;
            @(posedge clk);
            ms = mstep(ms, 3, 1, 4, lk, wr);
            mw = mw | wr;
            ml = ml | lk;
            @(negedge clk);
        end
        chk("w4_first_wrap", 32'(first), 32'd15);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
